// File: rtl/sobel_filter_3x3.sv
// 3x3 Sobel edge filter over a streaming grey image: two line buffers feed a
// sliding window, followed by gradient and magnitude/saturation stages.
module sobel_filter_3x3 #(
  parameter int DATA_W = 12,
  parameter int LINE_W = 640,
  parameter int SHIFT  = 2
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [DATA_W-1:0] iDATA,
  input  logic              iDVAL,
  input  logic [15:0]       iX_Cont,
  input  logic [15:0]       iY_Cont,
  input  logic [1:0]        iMODE,
  output logic [DATA_W-1:0] oDATA,
  output logic              oDVAL,
  output logic [1:0]        oMODE
);

  localparam int AW = (LINE_W > 1) ? $clog2(LINE_W) : 1;
  localparam int GW = DATA_W + 4;
  localparam logic [GW-1:0] SAT_MAX = {4'b0000, {DATA_W{1'b1}}};

  logic [DATA_W-1:0] line0 [LINE_W];
  logic [DATA_W-1:0] line1 [LINE_W];

  logic              in_range;
  logic              edge_pix;
  logic              frame_start;
  logic [AW-1:0]     addr;
  logic [DATA_W-1:0] line0_rd;
  logic [DATA_W-1:0] line1_rd;

  always_comb begin
    in_range    = ({16'd0, iX_Cont} < 32'(LINE_W));
    addr        = iX_Cont[AW-1:0];
    line0_rd    = in_range ? line0[addr] : '0;
    line1_rd    = in_range ? line1[addr] : '0;
    edge_pix    = (iX_Cont < 16'd2) || (iY_Cont < 16'd2) || !in_range;
    frame_start = (iX_Cont == '0) && (iY_Cont == '0);
  end

  // Line buffers are deliberately not reset; stale rows are masked by edge_pix.
  always_ff @(posedge iCLK) begin
    if (!iRST && iDVAL && in_range) begin
      line0[addr] <= iDATA;
      line1[addr] <= line0[addr];
    end
  end

  // Stage 1: window shift, edge mask and active-mode latch
  logic [DATA_W-1:0] p [3][3];
  logic              v1, m1;
  logic [1:0]        md1;
  logic [1:0]        mode_q;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      for (int unsigned r = 0; r < 3; r++) begin
        for (int unsigned c = 0; c < 3; c++) begin
          p[r][c] <= '0;
        end
      end
      v1     <= 1'b0;
      m1     <= 1'b0;
      md1    <= '0;
      mode_q <= '0;
    end else begin
      v1 <= iDVAL;
      m1 <= iDVAL && edge_pix;
      if (iDVAL) begin
        for (int unsigned r = 0; r < 3; r++) begin
          p[r][0] <= p[r][1];
          p[r][1] <= p[r][2];
        end
        p[0][2] <= line1_rd;
        p[1][2] <= line0_rd;
        p[2][2] <= iDATA;
        // Mode travels with each pixel so a frame start cannot recolour pixels in flight.
        if (frame_start) begin
          mode_q <= iMODE;
          md1    <= iMODE;
        end else begin
          md1    <= mode_q;
        end
      end
    end
  end

  // Stage 2: signed gradients
  function automatic logic signed [GW-1:0] ext(input logic [DATA_W-1:0] v);
    return {4'b0000, v};
  endfunction

  logic signed [GW-1:0] gx_c, gy_c;
  logic signed [GW-1:0] gx_q, gy_q;
  logic [DATA_W-1:0]    c2;
  logic                 v2, m2;
  logic [1:0]           md2;

  always_comb begin
    gx_c = (ext(p[0][2]) + (ext(p[1][2]) <<< 1) + ext(p[2][2]))
         - (ext(p[0][0]) + (ext(p[1][0]) <<< 1) + ext(p[2][0]));
    gy_c = (ext(p[2][0]) + (ext(p[2][1]) <<< 1) + ext(p[2][2]))
         - (ext(p[0][0]) + (ext(p[0][1]) <<< 1) + ext(p[0][2]));
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      v2   <= 1'b0;
      m2   <= 1'b0;
      gx_q <= '0;
      gy_q <= '0;
      c2   <= '0;
      md2  <= '0;
    end else begin
      v2 <= v1;
      m2 <= m1;
      if (v1) begin
        gx_q <= gx_c;
        gy_q <= gy_c;
        c2   <= p[1][1];
        md2  <= md1;
      end
    end
  end

  // Stage 3: magnitude, combine, shift, saturate
  logic [GW-1:0]     abs_x, abs_y, sel, shifted;
  logic [DATA_W-1:0] result;

  always_comb begin
    abs_x = gx_q[GW-1] ? GW'(-gx_q) : GW'(gx_q);
    abs_y = gy_q[GW-1] ? GW'(-gy_q) : GW'(gy_q);
    case (md2)
      2'd1:    sel = abs_x;
      2'd2:    sel = abs_y;
      default: sel = abs_x + abs_y;
    endcase
    shifted = sel >> SHIFT;
    if (md2 == 2'd0) begin
      result = c2;
    end else if (shifted > SAT_MAX) begin
      result = '1;
    end else begin
      result = shifted[DATA_W-1:0];
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      oDVAL <= 1'b0;
      oDATA <= '0;
    end else begin
      oDVAL <= v2;
      oDATA <= (v2 && !m2) ? result : '0;
    end
  end

  assign oMODE = mode_q;

endmodule

// File: tb/tb_sobel_filter_3x3.sv
// Directed bench for sobel_filter_3x3: whole-frame checks against a frame-based
// Sobel reference plus hand-computed spot values, valid timing and reset cases.
module tb_sobel_filter_3x3;

  logic        clk = 1'b0;
  logic        rst;
  logic        dval;
  logic [11:0] data;
  logic [15:0] xc;
  logic [15:0] yc;
  logic [1:0]  mode;
  logic [11:0] odata;
  logic        odval;
  logic [1:0]  omode;

  int tests = 0;
  int fails = 0;

  logic [11:0] out_q[$];
  int          img[16][16];
  bit          mon_en = 1'b0;
  logic        obs_v[12];
  logic [11:0] obs_d[12];

  always #5 clk = ~clk;

  sobel_filter_3x3 #(.DATA_W(12), .LINE_W(16), .SHIFT(2)) dut (
    .iCLK(clk), .iRST(rst), .iDATA(data), .iDVAL(dval),
    .iX_Cont(xc), .iY_Cont(yc), .iMODE(mode),
    .oDATA(odata), .oDVAL(odval), .oMODE(omode)
  );

  // Collect valid outputs; idle cycles must carry zero data
  always @(negedge clk) begin
    if (mon_en) begin
      if (odval) begin
        out_q.push_back(odata);
      end else begin
        tests++;
        assert (odata === 12'd0) else begin
          fails++;
          $error("FAIL idle_data observed=%0d expected=0", odata);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic v, input int d, input int x, input int y, input logic [1:0] m);
    @(negedge clk);
    dval = v;
    data = 12'(d);
    xc   = 16'(x);
    yc   = 16'(y);
    mode = m;
  endtask

  function automatic int pix(input int kind, input int x, input int y);
    case (kind)
      0:       return 100;
      1:       return (x >= 8) ? 1000 : 0;
      2:       return (x < 8) ? 1000 : 0;
      default: return (x >= 8 && y >= 8) ? 4095 : 0;
    endcase
  endfunction

  // Reference: window centred one column/row behind the triggering pixel
  function automatic int exp_pix(input int x, input int y, input int m);
    int cx, cy, gx, gy, r;
    if (x < 2 || y < 2) return 0;
    cx = x - 1;
    cy = y - 1;
    gx = (img[cy-1][cx+1] + 2*img[cy][cx+1] + img[cy+1][cx+1])
       - (img[cy-1][cx-1] + 2*img[cy][cx-1] + img[cy+1][cx-1]);
    gy = (img[cy+1][cx-1] + 2*img[cy+1][cx] + img[cy+1][cx+1])
       - (img[cy-1][cx-1] + 2*img[cy-1][cx] + img[cy-1][cx+1]);
    if (gx < 0) gx = -gx;
    if (gy < 0) gy = -gy;
    case (m)
      0:       return img[cy][cx];
      1:       r = gx;
      2:       r = gy;
      default: r = gx + gy;
    endcase
    r = r / 4;
    return (r > 4095) ? 4095 : r;
  endfunction

  function automatic logic [11:0] qget(input int i);
    if (i < out_q.size()) return out_q[i];
    return 'x;
  endfunction

  task automatic send_frame(input int kind, input logic [1:0] ma, input logic [1:0] mb, input int sw_row);
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++)
        img[y][x] = pix(kind, x, y);
    out_q.delete();
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++)
        drive(1'b1, img[y][x], x, y, (y < sw_row) ? ma : mb);
    for (int i = 0; i < 6; i++) drive(1'b0, 0, 0, 0, mb);
  endtask

  task automatic check_frame(input string tag, input int m);
    check({tag, "_count"}, out_q.size(), 256);
    for (int i = 0; i < 256; i++)
      check(tag, qget(i), exp_pix(i % 16, i / 16, m));
  endtask

  // Drives dval from pat (bit 0 first) and samples outputs before each drive
  task automatic run_pattern(input logic [7:0] pat, input int x, input int y, input int d);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      obs_v[i] = odval;
      obs_d[i] = odata;
      dval = (i < 8) ? pat[i] : 1'b0;
      data = 12'(d);
      xc   = 16'(x);
      yc   = 16'(y);
    end
    dval = 1'b0;
  endtask

  initial begin
    logic [7:0] pat;
    logic       ev;
    rst = 1'b1; dval = 1'b0; data = '0; xc = '0; yc = '0; mode = 2'd0;
    repeat (3) @(negedge clk);
    check("rst_dval", odval, 0);
    check("rst_data", odata, 0);
    check("rst_mode", omode, 0);
    rst = 1'b0;
    mon_en = 1'b1;

    // Flat frame, passthrough
    send_frame(0, 2'd0, 2'd0, 99);
    check_frame("flat_m0", 0);
    check("flat_22", qget(2*16+2), 100);
    check("flat_edge", qget(1*16+5), 0);
    check("flat_mode", omode, 0);

    // Valid pattern 1,0,0,1,1 delayed by 3, data passes centre 100
    pat = 8'b0001_1001;
    run_pattern(pat, 5, 5, 100);
    for (int i = 0; i < 12; i++) begin
      ev = (i >= 3 && i < 11) ? pat[i-3] : 1'b0;
      check("pat_dval", obs_v[i], ev);
      check("pat_data", obs_d[i], ev ? 100 : 0);
    end

    // Column beyond the line buffer: valid but forced to zero
    run_pattern(8'b0000_0001, 16, 5, 100);
    check("oor_dval", obs_v[3], 1);
    check("oor_data", obs_d[3], 0);
    check("oor_prev", obs_v[2], 0);

    send_frame(1, 2'd1, 2'd1, 99);
    check_frame("stepup_m1", 1);
    check("stepup_c7", qget(2*16+8), 1000);
    check("stepup_c8", qget(5*16+9), 1000);
    check("stepup_c9", qget(5*16+10), 0);
    check("stepup_mode", omode, 1);

    send_frame(1, 2'd2, 2'd2, 99);
    check_frame("stepup_m2", 2);
    check("stepup_m2_c7", qget(5*16+8), 0);
    check("m2_mode", omode, 2);

    // iMODE 1 at frame start, switched to 2 at row 5: must not take effect
    send_frame(2, 2'd1, 2'd2, 5);
    check_frame("stepdn_m1", 1);
    check("stepdn_c8", qget(5*16+9), 1000);
    check("midframe_mode", omode, 1);

    send_frame(1, 2'd2, 2'd2, 99);
    check("nextframe_mode", omode, 2);
    check_frame("stepup_m2b", 2);

    send_frame(3, 2'd3, 2'd3, 99);
    check_frame("quad_m3", 3);
    check("quad_88", qget(9*16+9), 4095);
    check("quad_22", qget(3*16+3), 0);
    check("quad_mode", omode, 3);

    // Reset mid-line with a pixel presented in the same cycle
    for (int x = 0; x < 6; x++) drive(1'b1, 500, x, 3, 2'd3);
    @(negedge clk);
    rst = 1'b1; dval = 1'b1; xc = 16'd6;
    @(negedge clk);
    check("midrst_dval", odval, 0);
    check("midrst_data", odata, 0);
    check("midrst_mode", omode, 0);
    rst = 1'b0; dval = 1'b0;
    run_pattern(8'b0000_0001, 4, 4, 700);
    check("restart_d0", obs_v[0], 0);
    check("restart_d2", obs_v[2], 0);
    check("restart_d3", obs_v[3], 1);
    check("restart_d4", obs_v[4], 0);
    check("restart_mode", omode, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sobel_filter_3x3.md
SOBEL_FILTER_3X3 -- requirements
Module: sobel_filter_3x3

Interface
REQ-001 SHALL have parameter DATA_W, default 12, meaning pixel width in bits.
REQ-002 SHALL have parameter LINE_W, default 640, meaning maximum pixels per line (line-buffer depth).
REQ-003 SHALL have parameter SHIFT, default 2, meaning right shift applied to gradient before saturation.
REQ-004 SHALL have port iCLK, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port iRST, input, 1, synchronous active-high reset.
REQ-006 SHALL have port iDATA, input, DATA_W, grey pixel in.
REQ-007 SHALL have port iDVAL, input, 1, meaning iDATA valid this cycle.
REQ-008 SHALL have port iX_Cont, input, 16, column of the current input pixel.
REQ-009 SHALL have port iY_Cont, input, 16, row of the current input pixel.
REQ-010 SHALL have port iMODE, input, 2: 0 passthrough, 1 |Gx|, 2 |Gy|, 3 |Gx|+|Gy|.
REQ-011 SHALL have port oDATA, output, DATA_W, filtered pixel.
REQ-012 SHALL have port oDVAL, output, 1, meaning oDATA valid.
REQ-013 SHALL have port oMODE, output, 2, the mode currently in effect.

Function
REQ-014 SHALL hold two line buffers of LINE_W x DATA_W, addressed by iX_Cont, written only on iDVAL with iX_Cont < LINE_W.
REQ-015 SHALL maintain a 3x3 window p[r][c] (r,c in 0..2; row 2 and column 2 newest) that shifts one column only on iDVAL; column 2 = {line buffer 1 [x], line buffer 0 [x], iDATA}.
REQ-016 SHALL keep line buffer 1 equal to the previous contents of line buffer 0 at the same address (rows y-2, y-1).
REQ-017 SHALL assert oDVAL exactly 3 cycles after each iDVAL-high cycle, with no gaps or merges; iDVAL-low cycles pass through as oDVAL-low.
REQ-018 SHALL compute on a 3-stage pipeline: stage 1 window shift, stage 2 signed Gx/Gy, stage 3 abs/combine/shift/saturate.
REQ-019 SHALL compute Gx = (p02+2p12+p22)-(p00+2p10+p20) and Gy = (p20+2p21+p22)-(p00+2p01+p02), both signed at DATA_W+4 bits without overflow.
REQ-020 SHALL output, for modes 1/2/3, (|Gx|, |Gy|, |Gx|+|Gy|) >> SHIFT, saturated to 2^DATA_W-1.
REQ-021 SHALL output the centre pixel p11 in mode 0.
REQ-022 SHALL force oDATA to 0, with oDVAL still asserted, when the triggering input had iX_Cont<2, iY_Cont<2 or iX_Cont>=LINE_W.
REQ-023 SHALL latch iMODE into the active mode only on an iDVAL cycle with iX_Cont==0 and iY_Cont==0; changes elsewhere take effect at the next frame start.
REQ-024 SHALL align each output pixel with the window centred at column x-1, row y-1 of its triggering input.
REQ-025 SHALL drive oDATA to 0 whenever oDVAL is low.

Reset
REQ-026 SHALL, on iRST high at a clock edge, clear the window registers, pipeline valid bits, oDATA, oDVAL and the active mode to 0 (passthrough).
REQ-027 SHALL hold oDVAL=0 from the cycle after iRST is sampled high until 3 cycles after the first post-reset iDVAL.
REQ-028 SHALL NOT clear line buffer contents on reset; REQ-022 masks the stale rows.
REQ-029 SHALL have iRST take priority over iDVAL in the same cycle; that pixel is discarded.

Verification
REQ-030 Flat 16x16 frame, value 100, mode 0 -> oDATA=100 for x,y>=2, 0 elsewhere; oDVAL count = 256.
REQ-031 Vertical step (0 for x<8, 1000 for x>=8), mode 1, SHIFT=2 -> oDATA=1000 at centre columns 7 and 8, 0 elsewhere; mode 2 -> all 0.
REQ-032 Quadrant 4095 (x>=8 and y>=8), mode 3 -> Gx=Gy=12285 at centre (8,8), oDATA saturates to 4095.
REQ-033 iMODE changed 1->2 mid-frame -> oMODE stays 1 until the next (0,0) pixel, then 2.
REQ-034 iDVAL pattern 1,0,0,1,1 -> oDVAL pattern identical, shifted 3 cycles.
REQ-035 iRST pulsed mid-line -> oDVAL=0 and oDATA=0 next cycle; after restart, first valid output appears 3 cycles after the first iDVAL; mode reads 0.
